// File: rtl/latch_reg_bank.sv
// Multi-entry register bank: one write port, two registered read ports,
// optional hardwired-zero entry 0 and optional write-to-read forwarding.
module latch_reg_bank #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             RE_A,
  input  logic [AW-1:0]    RADDR_A,
  input  logic             RE_B,
  input  logic [AW-1:0]    RADDR_B,
  output logic [WIDTH-1:0] RDATA_A,
  output logic [WIDTH-1:0] RDATA_B
);

  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [AW-1:0] addr);
    return {1'b0, addr} < DEPTH_L;
  endfunction

  function automatic logic is_zero_entry(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  logic write_ok;
  assign write_ok = WE && in_range(WADDR) && !is_zero_entry(WADDR);

  // Read sees the pre-edge entry unless forwarding picks up this edge's write.
  function automatic logic [WIDTH-1:0] read_val(input logic [AW-1:0] addr);
    if (!in_range(addr))
      return '0;
    if (is_zero_entry(addr))
      return '0;
    if ((BYPASS != 0) && WE && (WADDR == addr))
      return WDATA;
    return mem[addr];
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      RDATA_A <= '0;
      RDATA_B <= '0;
    end else begin
      if (write_ok)
        mem[WADDR] <= WDATA;
      if (RE_A)
        RDATA_A <= read_val(RADDR_A);
      if (RE_B)
        RDATA_B <= read_val(RADDR_B);
    end
  end

endmodule
